// File: rtl/matrix_input_responder_pkg.sv
// Shared types and constants for the matrix input responder.
// FSM state encoding, task codes, ASCII tokens, LFSR step.
package matrix_input_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_RD_M,
        S_RD_N,
        S_WAIT_ADDR,
        S_RD_ELEM,
        S_GEN_ELEM,
        S_FINISH,
        S_RD_ID,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [1:0] TASK_STORE = 2'd0;
    localparam logic [1:0] TASK_DIMS  = 2'd1;
    localparam logic [1:0] TASK_ID    = 2'd2;

    localparam logic [7:0] ASCII_0     = 8'h30;
    localparam logic [7:0] ASCII_9     = 8'h39;
    localparam logic [7:0] ASCII_SP    = 8'h20;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_COMMA = 8'h2C;

    // Maximal-length 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1)
    function automatic logic [7:0] lfsr8_next(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

endpackage

// File: rtl/matrix_input_responder_if.sv
// Controller/RAM/UART bundle seen by the input responder.
// master = controller side, slave = responder side.
interface matrix_input_responder_if #(
    parameter int DATA_W = 8
);
    logic              en;
    logic              is_gen_mode;
    logic [1:0]        task_mode;
    logic              addr_ready;
    logic [7:0]        base_addr;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              dims_valid;
    logic [31:0]       dim_m;
    logic [31:0]       dim_n;
    logic [31:0]       id_val;
    logic              id_valid;
    logic              rx_done;
    logic              error_flag;
    logic              mem_we;
    logic [7:0]        mem_addr;
    logic [DATA_W-1:0] mem_wdata;

    modport master (
        output en, is_gen_mode, task_mode,
        output addr_ready, base_addr,
        output rx_data, rx_valid,
        input  dims_valid, dim_m, dim_n,
        input  id_val, id_valid, rx_done, error_flag,
        input  mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  en, is_gen_mode, task_mode,
        input  addr_ready, base_addr,
        input  rx_data, rx_valid,
        output dims_valid, dim_m, dim_n,
        output id_val, id_valid, rx_done, error_flag,
        output mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/matrix_input_responder_parser.sv
// ASCII decimal tokenizer: digits accumulate (saturating at 255),
// space/CR/LF/comma close a non-empty token, anything else is an error.
module ascii_token_parser
    import matrix_input_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_clear,
    input  logic [7:0] i_byte,
    input  logic       i_valid,
    output logic       o_tok_valid,
    output logic [7:0] o_tok_val,
    output logic       o_tok_err
);

    logic [7:0]  r_acc;
    logic        r_seen;
    logic        r_tok_valid;
    logic [7:0]  r_tok_val;
    logic        r_tok_err;
    logic        w_is_digit;
    logic        w_is_delim;
    logic [3:0]  w_digit;
    logic [11:0] w_sum;
    logic [7:0]  w_acc_sat;

    assign w_is_digit = (i_byte >= ASCII_0) && (i_byte <= ASCII_9);
    assign w_is_delim = (i_byte == ASCII_SP) || (i_byte == ASCII_CR) ||
                        (i_byte == ASCII_LF) || (i_byte == ASCII_COMMA);
    assign w_digit    = 4'(i_byte - ASCII_0);
    assign w_sum      = ({4'd0, r_acc} * 12'd10) + {8'd0, w_digit};
    assign w_acc_sat  = (w_sum > 12'd255) ? 8'hFF : w_sum[7:0];

    // Accumulate digits; publish token/error one cycle after the closing byte
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc       <= 8'd0;
            r_seen      <= 1'b0;
            r_tok_valid <= 1'b0;
            r_tok_val   <= 8'd0;
            r_tok_err   <= 1'b0;
        end else begin
            r_tok_valid <= 1'b0;
            r_tok_err   <= 1'b0;
            if (i_clear) begin
                r_acc  <= 8'd0;
                r_seen <= 1'b0;
            end else if (i_valid) begin
                if (w_is_digit) begin
                    r_acc  <= w_acc_sat;
                    r_seen <= 1'b1;
                end else if (w_is_delim) begin
                    if (r_seen) begin
                        r_tok_valid <= 1'b1;
                        r_tok_val   <= r_acc;
                    end
                    r_acc  <= 8'd0;
                    r_seen <= 1'b0;
                end else begin
                    r_tok_err <= 1'b1;
                    r_acc     <= 8'd0;
                    r_seen    <= 1'b0;
                end
            end
        end
    end

    assign o_tok_valid = r_tok_valid;
    assign o_tok_val   = r_tok_val;
    assign o_tok_err   = r_tok_err;

endmodule

// File: rtl/matrix_input_responder.sv
// Input-subsystem responder: parses dims/elements/ID, writes matrix RAM.
// Optional GEN_MODE_EN macro builds the LFSR element generator.
module matrix_input_responder
    import matrix_input_pkg::*;
#(
    parameter int         DATA_W    = 8,
    parameter int         MAX_DIM   = 5,
    parameter int         MAX_ELEM  = 9,
    parameter logic [7:0] LFSR_SEED = 8'hA5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    matrix_input_responder_if.slave  io_bus
);

    localparam logic [7:0] LP_MAX_DIM  = 8'(MAX_DIM);
    localparam logic [7:0] LP_MAX_ELEM = 8'(MAX_ELEM);

    state_t            r_state;
    state_t            w_state_next;
    logic [1:0]        r_mode;
    logic [7:0]        r_base;
    logic [4:0]        r_idx;
    logic [4:0]        r_total;
    logic [31:0]       r_dim_m;
    logic [31:0]       r_dim_n;
    logic [31:0]       r_id_val;
    logic              r_id_valid;
    logic              r_rx_done;
    logic              r_dims_valid;
    logic              r_mem_we;
    logic [7:0]        r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;

    logic              w_consume;
    logic              w_tok_valid;
    logic [7:0]        w_tok_val;
    logic              w_tok_err;
    logic              w_dim_ok;
    logic              w_elem_ok;
    logic              w_last;
    logic [4:0]        w_prod;
    logic              w_we;
    logic [DATA_W-1:0] w_wdata;
    logic              w_done;
    logic              w_id_pulse;
    logic              w_dims_pulse;
    logic              w_latch_m;
    logic              w_latch_n;
    logic              w_latch_base;
    logic              w_idx_inc;
    logic              w_lfsr_step;

    assign w_consume = io_bus.en &&
                       ((r_state == S_RD_M) || (r_state == S_RD_N) ||
                        (r_state == S_RD_ELEM) || (r_state == S_RD_ID));

    ascii_token_parser u_parser (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_clear     (!w_consume),
        .i_byte      (io_bus.rx_data),
        .i_valid     (io_bus.rx_valid && w_consume),
        .o_tok_valid (w_tok_valid),
        .o_tok_val   (w_tok_val),
        .o_tok_err   (w_tok_err)
    );

    assign w_dim_ok  = (w_tok_val >= 8'd1) && (w_tok_val <= LP_MAX_DIM);
    assign w_elem_ok = (w_tok_val <= LP_MAX_ELEM);
    assign w_last    = (r_idx == (r_total - 5'd1));
    assign w_prod    = {2'd0, r_dim_m[2:0]} * {2'd0, w_tok_val[2:0]};

`ifdef GEN_MODE_EN
    localparam logic [7:0] LP_ELEM_MOD = 8'(MAX_ELEM + 1);
    logic [7:0] r_lfsr;
    logic [7:0] w_gen_val;

    assign w_gen_val = r_lfsr % LP_ELEM_MOD;

    // Generator LFSR advances once per generated write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr <= LFSR_SEED;
        end else if (w_lfsr_step) begin
            r_lfsr <= lfsr8_next(r_lfsr);
        end
    end
`else
    localparam logic [7:0] unused_seed = LFSR_SEED;
    logic w_unused_gen;
    assign w_unused_gen = io_bus.is_gen_mode;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode and per-cycle action strobes
    always_comb begin
        w_state_next = r_state;
        w_we         = 1'b0;
        w_wdata      = '0;
        w_done       = 1'b0;
        w_id_pulse   = 1'b0;
        w_dims_pulse = 1'b0;
        w_latch_m    = 1'b0;
        w_latch_n    = 1'b0;
        w_latch_base = 1'b0;
        w_idx_inc    = 1'b0;
        w_lfsr_step  = 1'b0;
        if (!io_bus.en) begin
            w_state_next = S_IDLE;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    unique case (io_bus.task_mode)
                        TASK_STORE: w_state_next = S_RD_M;
                        TASK_DIMS:  w_state_next = S_RD_M;
                        TASK_ID:    w_state_next = S_RD_ID;
                        default:    w_state_next = S_ERR;
                    endcase
                end
                S_RD_M: begin
                    if (w_tok_err) begin
                        w_state_next = S_ERR;
                    end else if (w_tok_valid) begin
                        if (w_dim_ok) begin
                            w_latch_m    = 1'b1;
                            w_state_next = S_RD_N;
                        end else begin
                            w_state_next = S_ERR;
                        end
                    end
                end
                S_RD_N: begin
                    if (w_tok_err) begin
                        w_state_next = S_ERR;
                    end else if (w_tok_valid) begin
                        if (!w_dim_ok) begin
                            w_state_next = S_ERR;
                        end else if (r_mode == TASK_DIMS) begin
                            w_latch_n    = 1'b1;
                            w_dims_pulse = 1'b1;
                            w_done       = 1'b1;
                            w_state_next = S_DONE;
                        end else begin
                            w_latch_n    = 1'b1;
                            w_state_next = S_WAIT_ADDR;
                        end
                    end
                end
                S_WAIT_ADDR: begin
                    if (io_bus.addr_ready) begin
                        w_latch_base = 1'b1;
`ifdef GEN_MODE_EN
                        w_state_next = io_bus.is_gen_mode ?
                                       S_GEN_ELEM : S_RD_ELEM;
`else
                        w_state_next = S_RD_ELEM;
`endif
                    end
                end
                S_RD_ELEM: begin
                    if (w_tok_err) begin
                        w_state_next = S_ERR;
                    end else if (w_tok_valid) begin
                        if (w_elem_ok) begin
                            w_we      = 1'b1;
                            w_wdata   = DATA_W'(w_tok_val);
                            w_idx_inc = 1'b1;
                            if (w_last) begin
                                w_state_next = S_FINISH;
                            end
                        end else begin
                            w_state_next = S_ERR;
                        end
                    end
                end
                S_GEN_ELEM: begin
`ifdef GEN_MODE_EN
                    w_we        = 1'b1;
                    w_wdata     = DATA_W'(w_gen_val);
                    w_idx_inc   = 1'b1;
                    w_lfsr_step = 1'b1;
                    if (w_last) begin
                        w_state_next = S_FINISH;
                    end
`else
                    w_state_next = S_IDLE;
`endif
                end
                S_FINISH: begin
                    w_done       = 1'b1;
                    w_state_next = S_DONE;
                end
                S_RD_ID: begin
                    if (w_tok_err) begin
                        w_state_next = S_ERR;
                    end else if (w_tok_valid) begin
                        w_id_pulse   = 1'b1;
                        w_done       = 1'b1;
                        w_state_next = S_DONE;
                    end
                end
                S_DONE:  w_state_next = S_DONE;
                S_ERR:   w_state_next = S_ERR;
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    // Task mode, dims, base address and element index bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode  <= TASK_STORE;
            r_dim_m <= 32'd0;
            r_dim_n <= 32'd0;
            r_total <= 5'd0;
            r_base  <= 8'd0;
            r_idx   <= 5'd0;
        end else begin
            if ((r_state == S_IDLE) && io_bus.en) begin
                r_mode <= io_bus.task_mode;
            end
            if (w_latch_m) begin
                r_dim_m <= {24'd0, w_tok_val};
            end
            if (w_latch_n) begin
                r_dim_n <= {24'd0, w_tok_val};
                r_total <= w_prod;
            end
            if (w_latch_base) begin
                r_base <= io_bus.base_addr;
                r_idx  <= 5'd0;
            end else if (w_idx_inc) begin
                r_idx <= r_idx + 5'd1;
            end
        end
    end

    // Registered handshake and RAM-write outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem_we     <= 1'b0;
            r_mem_addr   <= 8'd0;
            r_mem_wdata  <= '0;
            r_rx_done    <= 1'b0;
            r_id_valid   <= 1'b0;
            r_id_val     <= 32'd0;
            r_dims_valid <= 1'b0;
        end else begin
            r_mem_we     <= w_we;
            r_rx_done    <= w_done;
            r_id_valid   <= w_id_pulse;
            r_dims_valid <= w_dims_pulse ||
                            (w_state_next == S_WAIT_ADDR);
            if (w_we) begin
                r_mem_addr  <= r_base + {3'd0, r_idx};
                r_mem_wdata <= w_wdata;
            end
            if (w_id_pulse) begin
                r_id_val <= {24'd0, w_tok_val};
            end
        end
    end

    assign io_bus.dims_valid = r_dims_valid;
    assign io_bus.dim_m      = r_dim_m;
    assign io_bus.dim_n      = r_dim_n;
    assign io_bus.id_val     = r_id_val;
    assign io_bus.id_valid   = r_id_valid;
    assign io_bus.rx_done    = r_rx_done;
    assign io_bus.error_flag = (r_state == S_ERR);
    assign io_bus.mem_we     = r_mem_we;
    assign io_bus.mem_addr   = r_mem_addr;
    assign io_bus.mem_wdata  = r_mem_wdata;

endmodule

// File: tb/tb_matrix_input_responder.sv
// Directed bench for matrix_input_responder.
// Generator checks are built only with GEN_MODE_EN.
module tb_matrix_input_responder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    matrix_input_responder_if #(.DATA_W(8)) bus();

    matrix_input_responder #(
        .DATA_W    (8),
        .MAX_DIM   (5),
        .MAX_ELEM  (9),
        .LFSR_SEED (8'hA5)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_bus (bus)
    );

    int n_chk = 0;
    int n_bad = 0;
    int cyc = 0;
    logic [7:0] wr_addr[$];
    logic [7:0] wr_data[$];
    int wr_cyc[$];
    int n_done = 0;
    int n_dv = 0;
    int n_idv = 0;
    int done_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Log RAM writes and pulse counts, sampled away from the active edge
    always @(negedge clk) begin
        if (bus.mem_we) begin
            wr_addr.push_back(bus.mem_addr);
            wr_data.push_back(bus.mem_wdata);
            wr_cyc.push_back(cyc);
        end
        if (bus.rx_done) begin
            n_done = n_done + 1;
            done_cyc = cyc;
        end
        if (bus.dims_valid) n_dv = n_dv + 1;
        if (bus.id_valid) n_idv = n_idv + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        bus.rx_data = b;
        bus.rx_valid = 1'b1;
        @(negedge clk);
        bus.rx_valid = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
        idle(3);
    endtask

    task automatic start(input logic [1:0] mode, input logic gen);
        @(negedge clk);
        bus.task_mode = mode;
        bus.is_gen_mode = gen;
        bus.en = 1'b1;
        idle(2);
    endtask

    task automatic stop();
        @(negedge clk);
        bus.en = 1'b0;
        idle(2);
    endtask

    task automatic give_addr(input logic [7:0] b);
        @(negedge clk);
        bus.base_addr = b;
        bus.addr_ready = 1'b1;
        @(negedge clk);
        bus.addr_ready = 1'b0;
        idle(2);
    endtask

    int w0, d0, v0, i0;

    initial begin
        bus.en = 1'b0;
        bus.is_gen_mode = 1'b0;
        bus.task_mode = 2'd0;
        bus.addr_ready = 1'b0;
        bus.base_addr = 8'd0;
        bus.rx_data = 8'd0;
        bus.rx_valid = 1'b0;
        idle(3);
        chk("rst_dims_valid", 32'(bus.dims_valid), 0);
        chk("rst_mem_we", 32'(bus.mem_we), 0);
        chk("rst_error", 32'(bus.error_flag), 0);
        chk("rst_dim_m", bus.dim_m, 0);
        chk("rst_id_val", bus.id_val, 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        // store, manual: "2 3 " base 0x10, elements 1..6
        w0 = wr_addr.size();
        d0 = n_done;
        start(2'd0, 1'b0);
        give_addr(8'h99);
        send_str("2 3 ");
        chk("t1_dims_valid_held", 32'(bus.dims_valid), 1);
        chk("t1_dim_m", bus.dim_m, 2);
        chk("t1_dim_n", bus.dim_n, 3);
        give_addr(8'h10);
        chk("t1_dims_valid_drop", 32'(bus.dims_valid), 0);
        send_str("1 2 3 4 5 6 ");
        idle(3);
        chk("t1_nwr", 32'(wr_addr.size() - w0), 6);
        if (wr_addr.size() - w0 == 6) begin
            for (int i = 0; i < 6; i++) begin
                chk("t1_addr", 32'(wr_addr[w0+i]), 32'(8'h10 + i));
                chk("t1_data", 32'(wr_data[w0+i]), 32'(i + 1));
            end
            chk("t1_done_lat", 32'(done_cyc - wr_cyc[w0+5]), 1);
        end
        chk("t1_ndone", 32'(n_done - d0), 1);
        chk("t1_err", 32'(bus.error_flag), 0);
        stop();

        // dims only: "3 3\r"
        w0 = wr_addr.size();
        d0 = n_done;
        v0 = n_dv;
        start(2'd1, 1'b0);
        send_str("3 3\r");
        chk("t2_ndv", 32'(n_dv - v0), 1);
        chk("t2_dim_m", bus.dim_m, 3);
        chk("t2_dim_n", bus.dim_n, 3);
        chk("t2_ndone", 32'(n_done - d0), 1);
        chk("t2_nwr", 32'(wr_addr.size() - w0), 0);
        stop();

        // read ID: "2 ", then stays DONE while en high
        d0 = n_done;
        i0 = n_idv;
        start(2'd2, 1'b0);
        send_str("2 ");
        chk("t3_id_val", bus.id_val, 2);
        chk("t3_nidv", 32'(n_idv - i0), 1);
        chk("t3_ndone", 32'(n_done - d0), 1);
        send_str("7 ");
        chk("t3_id_hold", bus.id_val, 2);
        chk("t3_nidv_hold", 32'(n_idv - i0), 1);
        chk("t3_ndone_hold", 32'(n_done - d0), 1);
        stop();

        // errors: illegal dim, bad byte, bad task mode
        w0 = wr_addr.size();
        start(2'd0, 1'b0);
        send_str("6 2 ");
        chk("t4_err_dim", 32'(bus.error_flag), 1);
        give_addr(8'h20);
        chk("t4_nwr", 32'(wr_addr.size() - w0), 0);
        stop();
        chk("t4_err_clr", 32'(bus.error_flag), 0);
        start(2'd0, 1'b0);
        send_str("2 x");
        chk("t4_err_byte", 32'(bus.error_flag), 1);
        stop();
        start(2'd3, 1'b0);
        chk("t4_err_mode", 32'(bus.error_flag), 1);
        stop();
        chk("t4_err_clr2", 32'(bus.error_flag), 0);

        // en drops after 2 of 6 elements
        w0 = wr_addr.size();
        start(2'd0, 1'b0);
        send_str("2 3 ");
        give_addr(8'h40);
        send_str("1 2 ");
        chk("t6_nwr_mid", 32'(wr_addr.size() - w0), 2);
        @(negedge clk);
        bus.en = 1'b0;
        send_str("3 4 ");
        idle(2);
        chk("t6_nwr_after", 32'(wr_addr.size() - w0), 2);
        chk("t6_dim_kept", bus.dim_m, 2);

        // element out of range
        w0 = wr_addr.size();
        start(2'd0, 1'b0);
        send_str("1 1 ");
        give_addr(8'h50);
        send_str("12 ");
        chk("t6_err_elem", 32'(bus.error_flag), 1);
        chk("t6_nwr_elem", 32'(wr_addr.size() - w0), 0);
        stop();

        // manual address wrap at 0xFF
        w0 = wr_addr.size();
        d0 = n_done;
        start(2'd0, 1'b0);
        send_str("1,2\n");
        give_addr(8'hFF);
        send_str("3 4 ");
        chk("t7_nwr", 32'(wr_addr.size() - w0), 2);
        if (wr_addr.size() - w0 == 2) begin
            chk("t7_addr0", 32'(wr_addr[w0]), 32'h0FF);
            chk("t7_addr1", 32'(wr_addr[w0+1]), 32'h000);
            chk("t7_data1", 32'(wr_data[w0+1]), 4);
        end
        chk("t7_ndone", 32'(n_done - d0), 1);
        stop();

`ifdef GEN_MODE_EN
        // generator: "2 2 " base 0xFE
        w0 = wr_addr.size();
        d0 = n_done;
        start(2'd0, 1'b1);
        send_str("2 2 ");
        give_addr(8'hFE);
        idle(4);
        chk("t5_nwr", 32'(wr_addr.size() - w0), 4);
        if (wr_addr.size() - w0 == 4) begin
            chk("t5_addr0", 32'(wr_addr[w0]), 32'h0FE);
            chk("t5_addr1", 32'(wr_addr[w0+1]), 32'h0FF);
            chk("t5_addr2", 32'(wr_addr[w0+2]), 32'h000);
            chk("t5_addr3", 32'(wr_addr[w0+3]), 32'h001);
            for (int i = 0; i < 4; i++)
                chk("t5_data_range", 32'(wr_data[w0+i] <= 8'd9), 1);
            chk("t5_consec", 32'(wr_cyc[w0+3] - wr_cyc[w0]), 3);
        end
        chk("t5_ndone", 32'(n_done - d0), 1);
        stop();
`endif

        // async reset in the middle of a task
        start(2'd0, 1'b0);
        send_str("2 3 ");
        chk("t8_dv_pre", 32'(bus.dims_valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t8_dv_rst", 32'(bus.dims_valid), 0);
        chk("t8_dim_rst", bus.dim_m, 0);
        bus.en = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(2);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
